// File: rtl/fb_arb_pkg.sv
// Shared types for the framebuffer memory arbiter: port ids, FSM states and
// the read-return tag carried alongside each outstanding RAM read.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        PORT_DISP = 2'd0,
        PORT_CPU  = 2'd1,
        PORT_BLT  = 2'd2
    } port_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic  valid;
        port_e port;
    } rd_tag_t;

endpackage

// File: rtl/fb_rd_return_pipe.sv
// Delays the read tag by the RAM latency, then registers the RAM read data
// and steers it to the port that issued the read. Ports not addressed hold
// their last rdata value.
module fb_rd_return_pipe
    import fb_arb_pkg::*;
#(
    parameter int g_data_width  = 16,
    parameter int g_mem_latency = 1
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_i,
    input  rd_tag_t                 tag_i,
    input  logic [g_data_width-1:0] mem_rdata_i,
    output logic [g_data_width-1:0] disp_rdata_o,
    output logic                    disp_rvalid_o,
    output logic [g_data_width-1:0] cpu_rdata_o,
    output logic                    cpu_rvalid_o,
    output logic [g_data_width-1:0] blt_rdata_o,
    output logic                    blt_rvalid_o
);

    rd_tag_t                 r_tag [g_mem_latency];
    rd_tag_t                 w_tag_out;
    logic [g_data_width-1:0] r_disp_rdata;
    logic [g_data_width-1:0] r_cpu_rdata;
    logic [g_data_width-1:0] r_blt_rdata;
    logic                    r_disp_rvalid;
    logic                    r_cpu_rvalid;
    logic                    r_blt_rvalid;

    // The last stage lines up with the cycle in which mem_rdata_i is valid.
    assign w_tag_out = r_tag[g_mem_latency-1];

    // Tag delay line; reset flushes it so in-flight reads are forgotten.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            for (int i = 0; i < g_mem_latency; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= tag_i;
            for (int i = 1; i < g_mem_latency; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Register read data into the owning port and pulse its rvalid.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            r_disp_rdata  <= '0;
            r_cpu_rdata   <= '0;
            r_blt_rdata   <= '0;
            r_disp_rvalid <= 1'b0;
            r_cpu_rvalid  <= 1'b0;
            r_blt_rvalid  <= 1'b0;
        end else begin
            r_disp_rvalid <= 1'b0;
            r_cpu_rvalid  <= 1'b0;
            r_blt_rvalid  <= 1'b0;
            if (w_tag_out.valid) begin
                case (w_tag_out.port)
                    PORT_DISP: begin
                        r_disp_rdata  <= mem_rdata_i;
                        r_disp_rvalid <= 1'b1;
                    end
                    PORT_CPU: begin
                        r_cpu_rdata  <= mem_rdata_i;
                        r_cpu_rvalid <= 1'b1;
                    end
                    PORT_BLT: begin
                        r_blt_rdata  <= mem_rdata_i;
                        r_blt_rvalid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign disp_rdata_o  = r_disp_rdata;
    assign disp_rvalid_o = r_disp_rvalid;
    assign cpu_rdata_o   = r_cpu_rdata;
    assign cpu_rvalid_o  = r_cpu_rvalid;
    assign blt_rdata_o   = r_blt_rdata;
    assign blt_rvalid_o  = r_blt_rvalid;

endmodule

// File: rtl/fb_mem_arbiter.sv
// Framebuffer RAM arbiter: display burst reads have hard priority, CPU and
// blitter single accesses share the rest round-robin, with a starvation
// override that forces a single-port grant after too many display bursts.
//
// Handshake: a requester raises req with stable qualifiers and holds them
// until its ack_o pulses; ack_o is high in the same cycle the access is on
// the RAM port. A port whose ack_o is high is ignored by that cycle's
// arbitration, so a req still held during its ack is not granted twice.
module fb_mem_arbiter
    import fb_arb_pkg::*;
#(
    parameter int g_addr_width   = 17,
    parameter int g_data_width   = 16,
    parameter int g_mem_latency  = 1,
    parameter int g_max_burst    = 16,
    parameter int g_starve_limit = 8
) (
    input  logic                          clk_sys_i,
    input  logic                          rst_i,
    input  logic                          disp_req_i,
    input  logic [g_addr_width-1:0]       disp_addr_i,
    input  logic [$clog2(g_max_burst):0]  disp_len_i,
    output logic                          disp_ack_o,
    output logic [g_data_width-1:0]       disp_rdata_o,
    output logic                          disp_rvalid_o,
    input  logic                          cpu_req_i,
    input  logic                          cpu_we_i,
    input  logic [g_addr_width-1:0]       cpu_addr_i,
    input  logic [g_data_width-1:0]       cpu_wdata_i,
    output logic                          cpu_ack_o,
    output logic [g_data_width-1:0]       cpu_rdata_o,
    output logic                          cpu_rvalid_o,
    input  logic                          blt_req_i,
    input  logic                          blt_we_i,
    input  logic [g_addr_width-1:0]       blt_addr_i,
    input  logic [g_data_width-1:0]       blt_wdata_i,
    output logic                          blt_ack_o,
    output logic [g_data_width-1:0]       blt_rdata_o,
    output logic                          blt_rvalid_o,
    output logic                          mem_en_o,
    output logic                          mem_we_o,
    output logic [g_addr_width-1:0]       mem_addr_o,
    output logic [g_data_width-1:0]       mem_wdata_o,
    input  logic [g_data_width-1:0]       mem_rdata_i,
    output logic                          stat_starve_o,
    output arb_state_e                    dbg_state_o
);

    localparam int LEN_W = $clog2(g_max_burst) + 1;
    localparam int CNT_W = $clog2(g_starve_limit + 1);

    arb_state_e              r_state;
    arb_state_e              w_state_next;
    logic [LEN_W-1:0]        r_beats_left;
    logic [CNT_W-1:0]        r_starve_cnt;
    logic                    r_rr_blt;
    logic                    r_mem_en;
    logic                    r_mem_we;
    logic [g_addr_width-1:0] r_mem_addr;
    logic [g_data_width-1:0] r_mem_wdata;
    port_e                   r_mem_port;
    logic                    r_disp_ack;
    logic                    r_cpu_ack;
    logic                    r_blt_ack;
    logic                    r_stat_starve;

    logic                    w_disp_elig;
    logic                    w_cpu_elig;
    logic                    w_blt_elig;
    logic                    w_single_elig;
    logic                    w_pick_blt;
    logic [LEN_W-1:0]        w_len_eff;
    logic                    w_starve_hit;
    logic                    w_grant_disp;
    logic                    w_grant_cpu;
    logic                    w_grant_blt;
    rd_tag_t                 w_rd_tag;

    assign w_disp_elig   = disp_req_i & ~r_disp_ack;
    assign w_cpu_elig    = cpu_req_i & ~r_cpu_ack;
    assign w_blt_elig    = blt_req_i & ~r_blt_ack;
    assign w_single_elig = w_cpu_elig | w_blt_elig;
    assign w_pick_blt    = w_blt_elig & (~w_cpu_elig | r_rr_blt);

    // Zero-length bursts become one beat; oversize bursts are clamped.
    assign w_len_eff = (disp_len_i == '0) ? LEN_W'(1) :
                       (disp_len_i > LEN_W'(g_max_burst)) ? LEN_W'(g_max_burst) :
                       disp_len_i;

    // State register.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Arbitration and next state; IDLE also covers the cycle showing the last
    // burst beat, so back-to-back grants need no bubble.
    always_comb begin
        w_state_next = r_state;
        w_grant_disp = 1'b0;
        w_grant_cpu  = 1'b0;
        w_grant_blt  = 1'b0;
        w_starve_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_starve_hit = w_single_elig && (r_starve_cnt == CNT_W'(g_starve_limit));
                if (w_disp_elig && !w_starve_hit) begin
                    w_grant_disp = 1'b1;
                    if (w_len_eff > LEN_W'(1)) begin
                        w_state_next = ST_BURST;
                    end
                end else if (w_single_elig) begin
                    w_grant_blt = w_pick_blt;
                    w_grant_cpu = ~w_pick_blt;
                end
            end
            ST_BURST: begin
                if (r_beats_left == LEN_W'(1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Registered RAM port, acks and burst beat counter.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_port    <= PORT_DISP;
            r_beats_left  <= '0;
            r_disp_ack    <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_blt_ack     <= 1'b0;
            r_stat_starve <= 1'b0;
        end else begin
            r_disp_ack    <= w_grant_disp;
            r_cpu_ack     <= w_grant_cpu;
            r_blt_ack     <= w_grant_blt;
            r_stat_starve <= w_starve_hit;
            if (r_state == ST_BURST) begin
                r_mem_en     <= 1'b1;
                r_mem_we     <= 1'b0;
                r_mem_addr   <= r_mem_addr + 1'b1;
                r_mem_port   <= PORT_DISP;
                r_beats_left <= r_beats_left - 1'b1;
            end else if (w_grant_disp) begin
                r_mem_en     <= 1'b1;
                r_mem_we     <= 1'b0;
                r_mem_addr   <= disp_addr_i;
                r_mem_port   <= PORT_DISP;
                r_beats_left <= w_len_eff - 1'b1;
            end else if (w_grant_cpu) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= cpu_we_i;
                r_mem_addr  <= cpu_addr_i;
                r_mem_wdata <= cpu_wdata_i;
                r_mem_port  <= PORT_CPU;
            end else if (w_grant_blt) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= blt_we_i;
                r_mem_addr  <= blt_addr_i;
                r_mem_wdata <= blt_wdata_i;
                r_mem_port  <= PORT_BLT;
            end else begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
            end
        end
    end

    // Starvation counter and round-robin pointer (0 favours CPU).
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            r_starve_cnt <= '0;
            r_rr_blt     <= 1'b0;
        end else if (w_grant_cpu || w_grant_blt) begin
            r_starve_cnt <= '0;
            r_rr_blt     <= ~r_rr_blt;
        end else if (w_grant_disp && w_single_elig &&
                     (r_starve_cnt != CNT_W'(g_starve_limit))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_rd_tag.valid = r_mem_en & ~r_mem_we;
    assign w_rd_tag.port  = r_mem_port;

    fb_rd_return_pipe #(
        .g_data_width  (g_data_width),
        .g_mem_latency (g_mem_latency)
    ) u_rd_return (
        .clk_sys_i     (clk_sys_i),
        .rst_i         (rst_i),
        .tag_i         (w_rd_tag),
        .mem_rdata_i   (mem_rdata_i),
        .disp_rdata_o  (disp_rdata_o),
        .disp_rvalid_o (disp_rvalid_o),
        .cpu_rdata_o   (cpu_rdata_o),
        .cpu_rvalid_o  (cpu_rvalid_o),
        .blt_rdata_o   (blt_rdata_o),
        .blt_rvalid_o  (blt_rvalid_o)
    );

    assign disp_ack_o    = r_disp_ack;
    assign cpu_ack_o     = r_cpu_ack;
    assign blt_ack_o     = r_blt_ack;
    assign mem_en_o      = r_mem_en;
    assign mem_we_o      = r_mem_we;
    assign mem_addr_o    = r_mem_addr;
    assign mem_wdata_o   = r_mem_wdata;
    assign stat_starve_o = r_stat_starve;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: single accesses, burst length table, starvation
// override, reset mid-burst and CPU/blitter alternation against a RAM model.
module tb_fb_mem_arbiter;
    import fb_arb_pkg::*;

    localparam int AW     = 17;
    localparam int DW     = 16;
    localparam int LAT    = 1;
    localparam int MAXB   = 16;
    localparam int STARVE = 8;
    localparam int LW     = 5;
    localparam int RAM_N  = 1 << AW;

    logic            clk_sys_i = 1'b0;
    logic            rst_i;
    logic            disp_req_i;
    logic [AW-1:0]   disp_addr_i;
    logic [LW-1:0]   disp_len_i;
    logic            disp_ack_o;
    logic [DW-1:0]   disp_rdata_o;
    logic            disp_rvalid_o;
    logic            cpu_req_i;
    logic            cpu_we_i;
    logic [AW-1:0]   cpu_addr_i;
    logic [DW-1:0]   cpu_wdata_i;
    logic            cpu_ack_o;
    logic [DW-1:0]   cpu_rdata_o;
    logic            cpu_rvalid_o;
    logic            blt_req_i;
    logic            blt_we_i;
    logic [AW-1:0]   blt_addr_i;
    logic [DW-1:0]   blt_wdata_i;
    logic            blt_ack_o;
    logic [DW-1:0]   blt_rdata_o;
    logic            blt_rvalid_o;
    logic            mem_en_o;
    logic            mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [DW-1:0]   mem_rdata_i;
    logic            stat_starve_o;
    arb_state_e      dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_disp_q[$];
    logic [DW-1:0] exp_cpu_q[$];
    logic [DW-1:0] exp_blt_q[$];

    logic [DW-1:0] ram    [RAM_N];
    logic [DW-1:0] shadow [RAM_N];
    bit            ram_ready;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            exp_beats;
    } bvec_t;

    bvec_t bv[7];

    // Clock
    always #5 clk_sys_i = ~clk_sys_i;

    fb_mem_arbiter #(
        .g_addr_width   (AW),
        .g_data_width   (DW),
        .g_mem_latency  (LAT),
        .g_max_burst    (MAXB),
        .g_starve_limit (STARVE)
    ) dut (
        .clk_sys_i     (clk_sys_i),
        .rst_i         (rst_i),
        .disp_req_i    (disp_req_i),
        .disp_addr_i   (disp_addr_i),
        .disp_len_i    (disp_len_i),
        .disp_ack_o    (disp_ack_o),
        .disp_rdata_o  (disp_rdata_o),
        .disp_rvalid_o (disp_rvalid_o),
        .cpu_req_i     (cpu_req_i),
        .cpu_we_i      (cpu_we_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_wdata_i   (cpu_wdata_i),
        .cpu_ack_o     (cpu_ack_o),
        .cpu_rdata_o   (cpu_rdata_o),
        .cpu_rvalid_o  (cpu_rvalid_o),
        .blt_req_i     (blt_req_i),
        .blt_we_i      (blt_we_i),
        .blt_addr_i    (blt_addr_i),
        .blt_wdata_i   (blt_wdata_i),
        .blt_ack_o     (blt_ack_o),
        .blt_rdata_o   (blt_rdata_o),
        .blt_rvalid_o  (blt_rvalid_o),
        .mem_en_o      (mem_en_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .stat_starve_o (stat_starve_o),
        .dbg_state_o   (dbg_state_o)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a) ^ 16'h3C3C;
    endfunction

    // Single-port RAM model with one cycle read latency.
    always @(posedge clk_sys_i) begin
        if (!ram_ready) begin
            for (int i = 0; i < RAM_N; i++) begin
                ram[i] <= init_val(i);
            end
            ram_ready <= 1'b1;
        end else if (mem_en_o) begin
            if (mem_we_o) begin
                ram[mem_addr_o] <= mem_wdata_o;
            end else begin
                mem_rdata_i <= ram[mem_addr_o];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys_i);
        #1;
    endtask

    // Scoreboard: every rvalid pops the expected word for its port.
    always @(negedge clk_sys_i) begin
        if (disp_rvalid_o) begin
            if (exp_disp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL disp_rvalid_unexpected: got data 0x%0h expected no rvalid", disp_rdata_o);
            end else begin
                chk("disp_rdata", 32'(disp_rdata_o), 32'(exp_disp_q.pop_front()));
            end
        end
        if (cpu_rvalid_o) begin
            if (exp_cpu_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL cpu_rvalid_unexpected: got data 0x%0h expected no rvalid", cpu_rdata_o);
            end else begin
                chk("cpu_rdata", 32'(cpu_rdata_o), 32'(exp_cpu_q.pop_front()));
            end
        end
        if (blt_rvalid_o) begin
            if (exp_blt_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL blt_rvalid_unexpected: got data 0x%0h expected no rvalid", blt_rdata_o);
            end else begin
                chk("blt_rdata", 32'(blt_rdata_o), 32'(exp_blt_q.pop_front()));
            end
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_flags"}, 32'({disp_ack_o, disp_rvalid_o, cpu_ack_o, cpu_rvalid_o,
                                 blt_ack_o, blt_rvalid_o, mem_en_o, mem_we_o, stat_starve_o}), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr_o), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata_o), 32'd0);
        chk({tag, "_disp_rdata"}, 32'(disp_rdata_o), 32'd0);
        chk({tag, "_cpu_rdata"}, 32'(cpu_rdata_o), 32'd0);
        chk({tag, "_blt_rdata"}, 32'(blt_rdata_o), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state_o), 32'(ST_IDLE));
    endtask

    // One CPU or blitter access with the display idle.
    task automatic do_single(input bit is_blt, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd);
        logic rv;
        logic ack;
        if (!is_blt) begin
            cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
        end else begin
            blt_req_i = 1'b1; blt_we_i = we; blt_addr_i = addr; blt_wdata_i = wd;
        end
        if (we) begin
            shadow[addr] = wd;
        end else if (is_blt) begin
            exp_blt_q.push_back(shadow[addr]);
        end else begin
            exp_cpu_q.push_back(shadow[addr]);
        end
        tick();
        ack = is_blt ? blt_ack_o : cpu_ack_o;
        chk(is_blt ? "blt_ack" : "cpu_ack", 32'(ack), 32'd1);
        chk("single_mem_en", 32'(mem_en_o), 32'd1);
        chk("single_mem_we", 32'(mem_we_o), 32'(we));
        chk("single_mem_addr", 32'(mem_addr_o), 32'(addr));
        if (we) chk("single_mem_wdata", 32'(mem_wdata_o), 32'(wd));
        cpu_req_i = 1'b0;
        blt_req_i = 1'b0;
        for (int i = 1; i <= LAT + 1; i++) begin
            tick();
            rv = is_blt ? blt_rvalid_o : cpu_rvalid_o;
            chk("single_rvalid_timing", 32'(rv), 32'(!we && (i == LAT + 1)));
        end
    endtask

    // One display burst with nothing else requesting.
    task automatic do_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len, input int exp_beats);
        int            beats = 0;
        logic [AW-1:0] a;
        disp_req_i = 1'b1; disp_addr_i = addr; disp_len_i = len;
        for (int i = 0; i < exp_beats; i++) begin
            a = addr + AW'(i);
            exp_disp_q.push_back(shadow[a]);
        end
        tick();
        chk("disp_ack_first", 32'(disp_ack_o), 32'd1);
        disp_req_i = 1'b0;
        while (mem_en_o && beats < 40) begin
            a = addr + AW'(beats);
            chk("burst_addr", 32'(mem_addr_o), 32'(a));
            chk("burst_we", 32'(mem_we_o), 32'd0);
            if (beats > 0) chk("disp_ack_once", 32'(disp_ack_o), 32'd0);
            beats++;
            tick();
        end
        chk("burst_beats", 32'(beats), 32'(exp_beats));
        repeat (LAT + 2) tick();
        chk("disp_q_drained", 32'(exp_disp_q.size()), 32'd0);
    endtask

    initial begin : main
        logic [AW-1:0] ca;
        logic [AW-1:0] ba;
        logic [AW-1:0] a;
        int            n_bursts;
        bit            got;

        for (int i = 0; i < RAM_N; i++) shadow[i] = init_val(i);
        rst_i = 1'b1;
        disp_req_i = 1'b0; disp_addr_i = '0; disp_len_i = '0;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
        blt_req_i = 1'b0; blt_we_i = 1'b0; blt_addr_i = '0; blt_wdata_i = '0;
        repeat (3) tick();
        chk_idle_outputs("reset");
        rst_i = 1'b0;
        tick();

        // Single accesses: write then read back on each port.
        do_single(1'b0, 1'b1, 17'h00010, 16'hA5A5);
        do_single(1'b0, 1'b0, 17'h00010, 16'h0000);
        do_single(1'b1, 1'b1, 17'h00020, 16'h1234);
        do_single(1'b1, 1'b0, 17'h00020, 16'h0000);
        do_single(1'b1, 1'b0, 17'h00777, 16'h0000);

        // Burst length and address wrap table.
        bv[0] = '{17'h1FFFE, 5'd4,  4};
        bv[1] = '{17'h00100, 5'd0,  1};
        bv[2] = '{17'h00200, 5'd31, 16};
        bv[3] = '{17'h00300, 5'd1,  1};
        bv[4] = '{17'h00400, 5'd16, 16};
        bv[5] = '{17'h00500, 5'd17, 16};
        bv[6] = '{17'h1FFF8, 5'd15, 15};
        for (int v = 0; v < 7; v++) begin
            do_burst(bv[v].addr, bv[v].len, bv[v].exp_beats);
        end

        // Starvation: continuous len-16 display with one CPU read pending.
        disp_req_i = 1'b1; disp_addr_i = 17'h04000; disp_len_i = 5'd16;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 17'h00010;
        exp_cpu_q.push_back(shadow[17'h00010]);
        n_bursts = 0;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            tick();
            chk("stat_starve_with_cpu_ack", 32'(stat_starve_o), 32'(cpu_ack_o));
            if (disp_ack_o) begin
                n_bursts++;
                for (int i = 0; i < 16; i++) begin
                    a = 17'h04000 + AW'(i);
                    exp_disp_q.push_back(shadow[a]);
                end
            end
            if (cpu_ack_o) begin
                got = 1'b1;
                cpu_req_i = 1'b0;
            end
        end
        chk("starve_cpu_granted", 32'(got), 32'd1);
        chk("starve_burst_count", 32'(n_bursts), 32'(STARVE));
        tick();
        chk("starve_disp_resume", 32'(disp_ack_o), 32'd1);
        chk("starve_pulse_single", 32'(stat_starve_o), 32'd0);
        if (disp_ack_o) begin
            for (int i = 0; i < 16; i++) begin
                a = 17'h04000 + AW'(i);
                exp_disp_q.push_back(shadow[a]);
            end
        end
        disp_req_i = 1'b0;
        for (int c = 0; c < 40 && mem_en_o; c++) tick();
        repeat (LAT + 2) tick();
        chk("starve_disp_drained", 32'(exp_disp_q.size()), 32'd0);
        chk("starve_cpu_drained", 32'(exp_cpu_q.size()), 32'd0);

        // Reset in the middle of a burst with two reads in flight.
        disp_req_i = 1'b1; disp_addr_i = 17'h08000; disp_len_i = 5'd8;
        for (int i = 0; i < 8; i++) begin
            a = 17'h08000 + AW'(i);
            exp_disp_q.push_back(shadow[a]);
        end
        tick();
        chk("rst_burst_ack", 32'(disp_ack_o), 32'd1);
        disp_req_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        chk_idle_outputs("midburst_reset");
        exp_disp_q.delete();
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_rvalid_after_reset", 32'({disp_rvalid_o, cpu_rvalid_o, blt_rvalid_o, mem_en_o}), 32'd0);
        end

        // CPU and blitter both requesting continuously: CPU first, then alternate.
        ca = 17'h00600; ba = 17'h00800;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = ca;
        blt_req_i = 1'b1; blt_we_i = 1'b0; blt_addr_i = ba;
        exp_cpu_q.push_back(shadow[ca]);
        exp_blt_q.push_back(shadow[ba]);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("alt_mem_en", 32'(mem_en_o), 32'd1);
            chk("alt_cpu_ack", 32'(cpu_ack_o), 32'((i % 2) == 0));
            chk("alt_blt_ack", 32'(blt_ack_o), 32'((i % 2) == 1));
            chk("alt_mem_addr", 32'(mem_addr_o), 32'(((i % 2) == 0) ? ca : ba));
            if (cpu_ack_o) begin
                if (i < 10) begin
                    ca = ca + 17'd1;
                    cpu_addr_i = ca;
                    exp_cpu_q.push_back(shadow[ca]);
                end else begin
                    cpu_req_i = 1'b0;
                end
            end
            if (blt_ack_o) begin
                if (i < 10) begin
                    ba = ba + 17'd1;
                    blt_addr_i = ba;
                    exp_blt_q.push_back(shadow[ba]);
                end else begin
                    blt_req_i = 1'b0;
                end
            end
        end
        tick();
        chk("alt_idle_after", 32'(mem_en_o), 32'd0);
        repeat (LAT + 3) tick();

        chk("final_disp_q", 32'(exp_disp_q.size()), 32'd0);
        chk("final_cpu_q", 32'(exp_cpu_q.size()), 32'd0);
        chk("final_blt_q", 32'(exp_blt_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_mem_arbiter.md
# fb_mem_arbiter

Shares the single-port LCD framebuffer RAM between three requesters: display scan-out (burst reads, hard priority), the soft CPU (single read/write) and the blitter (single read/write). It sits between the CPU bus bridge, blitter and LCD timing generator on one side and the framebuffer BRAM on the other. It issues at most one memory access per cycle and routes read data back to the originating port.

## Interface
- g_addr_width, 17, framebuffer word address width
- g_data_width, 16, RAM word width
- g_mem_latency, 1, RAM read latency in cycles (1 or 2)
- g_max_burst, 16, maximum display burst length
- g_starve_limit, 8, consecutive display bursts allowed while a single-access port waits

Ports:
- clk_sys_i  in  1  system clock, sole clock
- rst_i  in  1  synchronous, active-high reset
- disp_req_i / disp_addr_i / disp_len_i  in  1 / g_addr_width / clog2(g_max_burst)+1  burst request, start address, length
- disp_ack_o  out  1  one-cycle pulse: burst accepted
- disp_rdata_o / disp_rvalid_o  out  g_data_width / 1  burst read data
- cpu_req_i / cpu_we_i / cpu_addr_i / cpu_wdata_i  in  1 / 1 / g_addr_width / g_data_width  CPU access
- cpu_ack_o  out  1  one-cycle pulse: access issued
- cpu_rdata_o / cpu_rvalid_o  out  g_data_width / 1  CPU read return
- blt_req_i / blt_we_i / blt_addr_i / blt_wdata_i  in  as CPU  blitter access
- blt_ack_o / blt_rdata_o / blt_rvalid_o  out  as CPU  blitter ack and read return
- mem_en_o / mem_we_o / mem_addr_o / mem_wdata_o  out  1 / 1 / g_addr_width / g_data_width  RAM port, registered
- mem_rdata_i  in  g_data_width  RAM read data
- stat_starve_o  out  1  pulses when a starvation override grant occurs

## Operation
- States: IDLE, BURST. Arbitration is evaluated in IDLE and in the last BURST beat, so consecutive grants are issued with no bubble.
- Priority: display > starvation override > round-robin between CPU and blitter. The round-robin pointer toggles after each single-port grant; after reset it favours CPU.
- Starvation counter: incremented per display grant while cpu_req_i or blt_req_i is pending and unserved, cleared on any single-port grant. When it equals g_starve_limit, the next grant goes to the round-robin single-port winner even if disp_req_i is high. The override also pulses stat_starve_o.
- Display burst: disp_len_i is sampled at grant. A value of 0 is treated as 1, and values above g_max_burst are clamped. Beats use addr, addr+1, … with wrap modulo 2^g_addr_width. Every beat is a read; mem_we_o=0.
- Single access: one beat, reads or writes per we_i. Writes produce no rvalid.
- Request rule: the requester holds req and its qualifiers stable until ack. A port whose ack_o is high in the current cycle is excluded from that cycle's arbitration, so a held req is not double-granted.
- Read return: a tag shift register (valid, port id) of depth g_mem_latency tracks outstanding reads. rdata is registered, then steered to one port with its rvalid. Other ports' rdata hold their last value.
- Reset: all outputs 0, state IDLE, counter 0, round-robin pointer favours CPU, tag pipe flushed. Reads in flight at reset never produce rvalid.

## Timing
- Grant decided in cycle N. mem_en_o and ack_o are both high in cycle N+1.
- rvalid arrives g_mem_latency+1 cycles after the corresponding mem_en_o cycle.
- Display burst of length L: mem_en_o is high for L consecutive cycles. disp_ack_o pulses on the first beat. disp_rvalid_o then gives L consecutive pulses.
- A single-port requester's maximum rate is one access per 2 cycles. Alternating CPU/blitter traffic reaches one access per cycle.
- CPU and blitter requesting in the same cycle: the round-robin winner is granted this cycle, and the other is granted in the next cycle if display is idle.

## Structure
- Package fb_arb_pkg holds the port-id enum (PORT_DISP, PORT_CPU, PORT_BLT), the state enum, and the tag struct {valid, port id}.
- Sub-module fb_rd_return_pipe implements the tag delay line plus rdata/rvalid steering, parameterised by g_mem_latency.

## Test plan
- CPU write 0xA5A5 to 0x00010, then read it back (g_mem_latency=1) -> cpu_ack_o 1 cycle after each req edge; cpu_rvalid_o with 0xA5A5 two cycles after the read's mem_en_o.
- Display burst addr 0x1FFFE, len 4 -> mem_addr_o 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 on 4 back-to-back cycles; 4 disp_rvalid_o pulses.
- CPU and blitter requesting continuously, display idle -> grants alternate CPU, blitter, CPU…, with mem_en_o high every cycle.
- Display requesting len 16 continuously with CPU pending -> exactly 8 display bursts, then one CPU grant with stat_starve_o pulse, then the counter restarts.
- disp_len_i=0 and disp_len_i=31 -> 1 beat and 16 beats respectively.
- rst_i asserted mid-burst with 2 reads in flight -> all outputs 0 the next cycle and no rvalid pulses afterward; the first grant after reset goes to CPU when CPU and blitter both request.
